// File: rtl/note_stream_tracker.sv
// note_stream_tracker: per-lane consumer of the (data_en, data) note-position
//   stream. Checks the start/step/wrap sequence, tracks position and lap count,
//   and scores one key press per lap that lands inside the hit window.
// Latency: one register stage; all outputs update the cycle after the input.
// Backpressure: none; the generator stream is sampled every cycle, never stalled.
//
// Optional build macro: KEY_SYNC_EN. When defined, key passes through a
//   two-flop synchronizer before edge detection, which delays hit by two cycles.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   map        lane active; samples are ignored while low
//   data_en    generator output-valid
//   data[7:0]  generator note position
//   key        player key for this lane (level)
//   pos[7:0]   last accepted in-sequence position
//   pos_valid  high while tracking
//   lap[7:0]   completed laps, wraps 255->0
//   hit        one-cycle pulse on a scored hit
//   miss       one-cycle pulse on a lap completed without a hit
//   score      hit count, saturating at all-ones
//   seq_err    sticky sequence-error flag

module note_stream_tracker #(
  parameter logic [7:0] START   = 8'd140,
  parameter logic [7:0] STEP    = 8'd4,
  parameter logic [7:0] LAST    = 8'd156,
  parameter logic [7:0] HIT_LO  = 8'd148,
  parameter logic [7:0] HIT_HI  = 8'd152,
  parameter int         SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               map,
  input  logic               data_en,
  input  logic [7:0]         data,
  input  logic               key,
  output logic [7:0]         pos,
  output logic               pos_valid,
  output logic [7:0]         lap,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic               seq_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]         pos_q, pos_d;
  logic               pos_valid_q, pos_valid_d;
  logic [7:0]         lap_q, lap_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               seq_err_q, seq_err_d;
  logic               hit_done_q, hit_done_d;
  logic               key_q;

  // ---------------------------------------------------------------------------
  // Key path: optional synchronizer, then rising-edge detector. Runs every
  // cycle regardless of map so a press held across a map change is not lost.
  // ---------------------------------------------------------------------------
  logic key_in;

`ifdef KEY_SYNC_EN
  logic key_s1_q, key_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q <= 1'b0;
      key_s2_q <= 1'b0;
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
    end
  end

  assign key_in = key_s2_q;
`else
  assign key_in = key;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_in;
    end
  end

  logic key_rise;
  assign key_rise = key_in & ~key_q;

  // ---------------------------------------------------------------------------
  // Sequence decode, all against the current (pre-update) position.
  // ---------------------------------------------------------------------------
  logic       accept;
  logic [7:0] expected;
  logic       is_start;
  logic       match;
  logic       at_last;
  logic       in_window;
  logic       seq_fail;
  logic       score_hit;

  assign accept    = map & data_en;
  assign at_last   = (pos_q == LAST);
  assign expected  = at_last ? START : (pos_q + STEP);
  assign is_start  = (data == START);
  assign match     = (data == expected);
  assign in_window = (pos_q >= HIT_LO) && (pos_q <= HIT_HI);

  // A key press that coincides with the sequence breaking does not score.
  assign seq_fail  = (state_q == S_TRACK) && accept && !match;
  assign score_hit = key_rise && (state_q == S_TRACK) && in_window &&
                     !hit_done_q && !seq_fail;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_start) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (accept && !match) state_d = S_ERROR;
      end
      S_ERROR: begin
        if (accept && is_start) state_d = S_TRACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: position, lap, scoring
  // ---------------------------------------------------------------------------
  always_comb begin
    pos_d      = pos_q;
    lap_d      = lap_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    seq_err_d  = seq_err_q;
    hit_done_d = hit_done_q;

    if (score_hit) begin
      hit_d      = 1'b1;
      hit_done_d = 1'b1;
      if (score_q != {SCORE_W{1'b1}}) begin
        score_d = score_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_ERROR: begin
        // Re-entry into tracking starts a fresh lap without counting it.
        if (accept && is_start) begin
          pos_d      = START;
          hit_done_d = 1'b0;
        end
      end
      S_TRACK: begin
        if (accept) begin
          if (match) begin
            pos_d = data;
            if (at_last) begin
              // Wrap closes the lap. A hit scored this same cycle belongs to
              // the closing lap, so it suppresses miss; the new lap starts clean.
              lap_d      = lap_q + 8'd1;
              miss_d     = !hit_done_q && !score_hit;
              hit_done_d = 1'b0;
            end
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    pos_valid_d = (state_d == S_TRACK);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q       <= 8'd0;
      pos_valid_q <= 1'b0;
      lap_q       <= 8'd0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      seq_err_q   <= 1'b0;
      hit_done_q  <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      lap_q       <= lap_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      seq_err_q   <= seq_err_d;
      hit_done_q  <= hit_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (straight from registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    pos       = pos_q;
    pos_valid = pos_valid_q;
    lap       = lap_q;
    hit       = hit_q;
    miss      = miss_q;
    score     = score_q;
    seq_err   = seq_err_q;
  end

endmodule

// File: doc/note_stream_tracker.md
Name: note_stream_tracker

Overview:
- Consumer end of the note data stream.
- Samples the (data_en, data) note-position stream emitted by the per-lane generators while map is active.
- Checks that the stream follows the expected start/step/wrap sequence and tracks position and lap count.
- Scores player key presses that land inside the lane's hit window. One instance per lane, between the lane generator and the score/display logic.

Parameters:
START, 140, first position of a lap (value after wrap)
STEP, 4, position increment per accepted sample
LAST, 156, final position of a lap; next expected value is START
HIT_LO, 148, lowest position (inclusive) counted as a hit
HIT_HI, 152, highest position (inclusive) counted as a hit
SCORE_W, 8, width of score counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
map  input  1  lane active; samples ignored when low
data_en  input  1  generator output-valid
data  input  8  generator note position
key  input  1  player key for this lane, level
pos  output  8  last accepted in-sequence position
pos_valid  output  1  high while in TRACK state
lap  output  8  completed laps, wraps 255->0
hit  output  1  one-cycle pulse on scored hit
miss  output  1  one-cycle pulse on lap completed without a hit
score  output  SCORE_W  hit count, saturating at all-ones
seq_err  output  1  sticky sequence-error flag

Behaviour:
- Reset values, held while reset is high: state=IDLE, pos=0, pos_valid=0, lap=0, hit=0, miss=0, score=0, seq_err=0, key history=0, hit_done=0. All outputs are registered.
- Accepted sample: map && data_en in a cycle. No other cycle changes pos, lap or state. Key edge detection runs every cycle regardless of map.
- expected = (pos == LAST) ? START : pos + STEP, using 8-bit arithmetic.
- IDLE state:
  - Accepted sample == START: go to TRACK, pos <= START, hit_done <= 0.
  - Any other accepted sample is ignored (not an error).
- TRACK state:
  - Accepted sample == expected: pos <= data.
  - If that sample is a wrap (pos == LAST and data == START): lap <= lap+1. If hit_done == 0, miss pulses in the same cycle. Then hit_done <= 0.
  - Accepted sample != expected: go to ERROR, seq_err <= 1, pos_valid <= 0, pos is held.
- ERROR state:
  - Accepted sample == START: return to TRACK, pos <= START, hit_done <= 0. seq_err stays set.
  - Other samples are ignored.
- Latency: pos, pos_valid and lap update in the cycle after the accepted sample appears on the inputs (one register stage).
- Key handling:
  - key_rise = key && !key_q, where key_q is key registered one cycle.
  - key_rise in TRACK with HIT_LO <= pos <= HIT_HI and hit_done == 0: hit pulses for one cycle, score <= score+1 (saturating), hit_done <= 1.
  - key_rise outside the window, in IDLE/ERROR, or with hit_done == 1: no effect. At most one hit per lap.
- Simultaneous events:
  - key_rise in the same cycle as an accepted sample: evaluated against pos before the update (old pos).
  - Wrap in the same cycle as a scoring key_rise: hit is scored to the closing lap, so miss does not pulse; hit_done then clears for the new lap.
  - seq_err asserting in the same cycle as key_rise: no score.
- Lap-0 start: entering TRACK from IDLE does not pulse miss and does not increment lap.
- Reset mid-operation: returns to IDLE immediately. Any in-flight pulse is cleared.

Optional Feature:
- Macro KEY_SYNC_EN.
- Defined: key passes through a two-flop synchronizer before the edge detector. key_rise, and therefore hit, is delayed by 2 extra cycles relative to the key input. Window comparison uses pos at evaluation time. Synchronizer flops reset to 0.
- Undefined: key is used directly; hit pulses the cycle after key rises.

Test Plan:
- Reset, then map=1, data_en=1, data=140,144,148,152,156,140 one per cycle -> pos_valid=1 from the cycle after 140. pos follows the data one cycle late. lap=1 and miss=1 for one cycle after the second 140. seq_err=0.
- Same stream with key rising while pos=148 -> hit pulse one cycle later, score=1. No miss at wrap. A second key rise at pos=152 in the same lap -> no hit, score stays 1.
- Stream 140,144,150 -> state ERROR, seq_err=1, pos held at 144, pos_valid=0. Then data=140 -> TRACK, pos=140, seq_err still 1.
- map=0 with data_en=1 and data=140 -> no change, state IDLE, pos_valid=0. Key rise in IDLE -> no hit.
- 255 full hit laps -> score=255; next hit -> score stays 255, hit still pulses. lap wraps from 255 to 0 on the 256th lap.
- Assert reset mid-lap at pos=148 with score=3 -> all outputs 0 the same cycle. Compile with KEY_SYNC_EN -> hit appears 3 cycles after the key rise.
